// File: rtl/alu_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants and controller state encoding.
// Imported by the datapath ALU and by the multi-cycle controller.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_ADDI = 4'b0001;
   localparam logic [3:0] ALU_LW   = 4'b0010;
   localparam logic [3:0] ALU_SW   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_ANDI = 4'b0110;
   localparam logic [3:0] ALU_NOR  = 4'b0111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_NOR = 6'h27;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: maps opcode/funct onto ALU code and datapath steering.
// Only op[31:26] and funct[5:0] take part; register and immediate fields are ignored.
module alu_seq_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic        reg_dst_rd,
   output logic        is_mem,
   output logic        is_store,
   output logic        illegal
);

   logic [5:0] op_s;
   logic [5:0] funct_s;
   logic       unused_fields_s;

   assign op_s            = instr[31:26];
   assign funct_s         = instr[5:0];
   assign unused_fields_s = ^instr[25:6];

   // opcode/funct lookup; anything not listed is flagged illegal
   always_comb begin
      alu_ctrl    = ALU_ADD;
      alu_src_imm = 1'b0;
      reg_dst_rd  = 1'b0;
      is_mem      = 1'b0;
      is_store    = 1'b0;
      illegal     = 1'b0;
      case (op_s)
         OP_RTYPE: begin
            reg_dst_rd = 1'b1;
            case (funct_s)
               FUNCT_ADD: alu_ctrl = ALU_ADD;
               FUNCT_SLL: alu_ctrl = ALU_SLL;
               FUNCT_AND: alu_ctrl = ALU_AND;
               FUNCT_NOR: alu_ctrl = ALU_NOR;
               default: begin
                  reg_dst_rd = 1'b0;
                  illegal    = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            alu_ctrl    = ALU_ADDI;
            alu_src_imm = 1'b1;
         end
         OP_ANDI: begin
            alu_ctrl    = ALU_ANDI;
            alu_src_imm = 1'b1;
         end
         OP_LW: begin
            alu_ctrl    = ALU_LW;
            alu_src_imm = 1'b1;
            is_mem      = 1'b1;
         end
         OP_SW: begin
            alu_ctrl    = ALU_SW;
            alu_src_imm = 1'b1;
            is_mem      = 1'b1;
            is_store    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/writeback, drives ALU code
// and datapath enables, handshakes the shared memory port and guards it with a watchdog.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic        reg_dst_rd,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        retired,
   output logic        illegal,
   output logic        bus_error,
   output logic [2:0]  state_dbg
);

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] wd_r;
   logic             bus_error_r;
   logic             waiting_s;
   logic             wd_expire_s;

   logic [3:0]       dec_alu_s;
   logic             dec_imm_s;
   logic             dec_rd_s;
   logic             dec_mem_s;
   logic             dec_store_s;
   logic             dec_illegal_s;

   logic [3:0]       lat_alu_r;
   logic             lat_imm_r;
   logic             lat_rd_r;
   logic             lat_mem_r;
   logic             lat_store_r;

   alu_seq_decode u_decode (
      .instr       (instr),
      .alu_ctrl    (dec_alu_s),
      .alu_src_imm (dec_imm_s),
      .reg_dst_rd  (dec_rd_s),
      .is_mem      (dec_mem_s),
      .is_store    (dec_store_s),
      .illegal     (dec_illegal_s)
   );

   // A wait cycle that would make the count reach TIMEOUT_CYCLES expires; mem_ready in that cycle wins.
   assign waiting_s   = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
   assign wd_expire_s = waiting_s && (wd_r == WD_LAST);

   // state register, watchdog counter and sticky bus error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         wd_r        <= '0;
         bus_error_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         bus_error_r <= bus_error_r | wd_expire_s;
         if (waiting_s && !wd_expire_s) begin
            wd_r <= wd_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            wd_r <= '0;
         end
      end
   end

   // decode result captured in DECODE and held through MEM/WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_alu_r   <= 4'b0000;
         lat_imm_r   <= 1'b0;
         lat_rd_r    <= 1'b0;
         lat_mem_r   <= 1'b0;
         lat_store_r <= 1'b0;
      end else if (state_r == ST_DECODE) begin
         lat_alu_r   <= dec_alu_s;
         lat_imm_r   <= dec_imm_s;
         lat_rd_r    <= dec_rd_s;
         lat_mem_r   <= dec_mem_s;
         lat_store_r <= dec_store_s;
      end else begin
         lat_alu_r   <= lat_alu_r;
         lat_imm_r   <= lat_imm_r;
         lat_rd_r    <= lat_rd_r;
         lat_mem_r   <= lat_mem_r;
         lat_store_r <= lat_store_r;
      end
   end

   // next-state and output decode; outputs derive from the async-reset state so they drop with rst_n
   always_comb begin
      next_state_s = state_r;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      alu_ctrl     = 4'b0000;
      alu_src_imm  = 1'b0;
      reg_dst_rd   = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      retired      = 1'b0;
      illegal      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (run && !bus_error_r) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write     = 1'b1;
               pc_write     = 1'b1;
               next_state_s = ST_DECODE;
            end else if (wd_expire_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (dec_illegal_s) begin
               illegal      = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_ctrl    = lat_alu_r;
            alu_src_imm = lat_imm_r;
            reg_dst_rd  = lat_rd_r;
            if (lat_mem_r) begin
               next_state_s = ST_MEM;
            end else begin
               next_state_s = ST_WB;
            end
         end
         ST_MEM: begin
            alu_ctrl    = lat_alu_r;
            alu_src_imm = lat_imm_r;
            reg_dst_rd  = lat_rd_r;
            mem_req     = 1'b1;
            mem_we      = lat_store_r;
            if (mem_ready) begin
               if (lat_store_r) begin
                  retired      = 1'b1;
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_WB;
               end
            end else if (wd_expire_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_MEM;
            end
         end
         ST_WB: begin
            alu_ctrl     = lat_alu_r;
            alu_src_imm  = lat_imm_r;
            reg_dst_rd   = lat_rd_r;
            reg_write    = 1'b1;
            mem_to_reg   = lat_mem_r & ~lat_store_r;
            retired      = 1'b1;
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   assign bus_error = bus_error_r;
   assign state_dbg = state_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, hand-written corner sequences,
// and randomized instructions checked against a transaction-level cycle/pulse model.
module tb_alu_seq_ctrl;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [31:0] instr;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   logic [3:0]  alu_ctrl;
   logic        alu_src_imm;
   logic        reg_dst_rd;
   logic        mem_to_reg;
   logic        reg_write;
   logic        retired;
   logic        illegal;
   logic        bus_error;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int lat; int ir; int pc; int rw; int ret; int ill; int we; int req;
      int alu; int imm; int rd; int m2r; int bus_err; int quiet; int fetch_alu;
   } obs_t;

   typedef struct {
      logic [31:0] ins; int fw; int mw;
      int lat; int alu; int rw; int ret; int ill;
   } vec_t;

   alu_seq_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
      .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .reg_dst_rd(reg_dst_rd),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retired(retired),
      .illegal(illegal), .bus_error(bus_error), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Reference: instruction class from opcode table, then cycle/pulse counts by arithmetic.
   function automatic obs_t model(input logic [31:0] ins, input int fw, input int mw);
      obs_t e;
      int code; int imm; int rd; bit ld; bit st; bit legal;
      logic [5:0] op; logic [5:0] fn;
      e = '{default: 0};
      e.quiet = 1;
      op = ins[31:26]; fn = ins[5:0];
      legal = 1'b1; code = 0; imm = 0; rd = 0; ld = 1'b0; st = 1'b0;
      case (op)
         6'h00: begin
            rd = 1;
            case (fn)
               6'h20: code = 0;
               6'h00: code = 4;
               6'h24: code = 5;
               6'h27: code = 7;
               default: legal = 1'b0;
            endcase
         end
         6'h08: begin code = 1; imm = 1; end
         6'h0C: begin code = 6; imm = 1; end
         6'h23: begin code = 2; imm = 1; ld = 1'b1; end
         6'h2B: begin code = 3; imm = 1; st = 1'b1; end
         default: legal = 1'b0;
      endcase
      if (fw >= TMO) begin
         e.lat = 1 + TMO; e.req = TMO; e.bus_err = 1;
         return e;
      end
      e.ir = 1; e.pc = 1; e.req = fw + 1;
      if (!legal) begin
         e.lat = 3 + fw; e.ill = 1;
         return e;
      end
      if (ld || st) begin
         if (mw >= TMO) begin
            e.lat = 4 + fw + TMO; e.req += TMO; e.we = st ? TMO : 0; e.bus_err = 1;
            return e;
         end
         e.req += mw + 1;
         e.we = st ? mw + 1 : 0;
      end
      e.lat = 5 + fw + ((ld || st) ? mw : 0) + (ld ? 1 : 0);
      e.rw  = st ? 0 : 1;
      e.ret = 1;
      e.alu = code; e.imm = imm; e.rd = rd; e.m2r = ld ? 1 : 0;
      return e;
   endfunction

   task automatic check_obs(input string tag, input obs_t a, input obs_t e);
      check_int({tag, ".latency"},   a.lat,       e.lat);
      check_int({tag, ".ir_write"},  a.ir,        e.ir);
      check_int({tag, ".pc_write"},  a.pc,        e.pc);
      check_int({tag, ".reg_write"}, a.rw,        e.rw);
      check_int({tag, ".retired"},   a.ret,       e.ret);
      check_int({tag, ".illegal"},   a.ill,       e.ill);
      check_int({tag, ".mem_we"},    a.we,        e.we);
      check_int({tag, ".mem_req"},   a.req,       e.req);
      check_int({tag, ".alu_ctrl"},  a.alu,       e.alu);
      check_int({tag, ".alu_imm"},   a.imm,       e.imm);
      check_int({tag, ".reg_dst"},   a.rd,        e.rd);
      check_int({tag, ".mem_to_reg"},a.m2r,       e.m2r);
      check_int({tag, ".bus_error"}, a.bus_err,   e.bus_err);
      check_int({tag, ".idle_quiet"},a.quiet,     e.quiet);
      check_int({tag, ".fetch_alu"}, a.fetch_alu, e.fetch_alu);
   endtask

   // Caller is mid-cycle in IDLE; that cycle counts as cycle 0 of the instruction.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input bit drop_run, output obs_t o);
      int k; int waits; int acc; bit prev_req; bit done;
      o = '{default: 0};
      instr = ins; run = 1'b1; mem_ready = 1'b0;
      k = 0; waits = 0; acc = 0; prev_req = 1'b0; done = 1'b0;
      while (!done) begin
         @(posedge clk); #1;
         k++;
         if (drop_run && k == 1) run = 1'b0;
         if (mem_req) begin
            if (!prev_req) begin
               waits = (acc == 0) ? fw : mw;
               acc++;
            end
            prev_req  = 1'b1;
            mem_ready = (waits == 0);
            if (waits > 0) waits--;
         end else begin
            prev_req  = 1'b0;
            mem_ready = 1'b0;
         end
         #1;
         if (state_dbg == 3'd0) begin
            done = 1'b1;
            run  = 1'b0;
            o.quiet = (mem_req | mem_we | ir_write | pc_write | (alu_ctrl != 4'b0000) |
                       alu_src_imm | reg_dst_rd | mem_to_reg | reg_write | retired | illegal) ? 0 : 1;
         end else begin
            o.ir  += int'(ir_write);
            o.pc  += int'(pc_write);
            o.rw  += int'(reg_write);
            o.ret += int'(retired);
            o.ill += int'(illegal);
            o.we  += int'(mem_we);
            o.req += int'(mem_req);
            if (ir_write && alu_ctrl != 4'b0000) o.fetch_alu++;
            if (retired) begin
               o.alu = int'(alu_ctrl);
               o.imm = int'(alu_src_imm);
               o.rd  = int'(reg_dst_rd);
               o.m2r = int'(mem_to_reg);
            end
         end
         if (k > 60 && !done) begin
            check_int("instr_cycle_budget", k, 60);
            done = 1'b1;
            run  = 1'b0;
         end
      end
      o.lat = k;
      o.bus_err = int'(bus_error);
      mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
      #1;
      check_int("reset_state",   int'(state_dbg), 0);
      check_int("reset_mem_req", int'(mem_req),   0);
      check_int("reset_alu",     int'(alu_ctrl),  0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check_int("release_mem_req",   int'(mem_req),   0);
      check_int("release_bus_error", int'(bus_error), 0);
      check_int("release_state",     int'(state_dbg), 0);
   endtask

   initial begin
      vec_t vt[12];
      obs_t o;
      obs_t e;
      int bad;
      int n;
      logic [31:0] r;
      logic [31:0] ins;
      int sel;

      rst_n = 1'b0; run = 1'b0; instr = 32'h0; mem_ready = 1'b0;

      vt[0]  = '{32'h012A4020, 0, 0, 5, 0, 1, 1, 0};
      vt[1]  = '{32'h8D090004, 0, 3, 9, 2, 1, 1, 0};
      vt[2]  = '{32'hAD090008, 0, 0, 5, 3, 0, 1, 0};
      vt[3]  = '{32'h3128000F, 0, 0, 5, 6, 1, 1, 0};
      vt[4]  = '{32'hFC000000, 0, 0, 3, 0, 0, 0, 1};
      vt[5]  = '{32'h00094080, 0, 0, 5, 4, 1, 1, 0};
      vt[6]  = '{32'h012A4024, 0, 0, 5, 5, 1, 1, 0};
      vt[7]  = '{32'h012A4027, 0, 0, 5, 7, 1, 1, 0};
      vt[8]  = '{32'h21280005, 0, 0, 5, 1, 1, 1, 0};
      vt[9]  = '{32'h012A4020, 3, 0, 8, 0, 1, 1, 0};
      vt[10] = '{32'hAD090008, 1, 2, 8, 3, 0, 1, 0};
      vt[11] = '{32'h012A4022, 0, 0, 3, 0, 0, 0, 1};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         run_instr(vt[i].ins, vt[i].fw, vt[i].mw, 1'b0, o);
         check_int($sformatf("vec%0d.latency", i), o.lat, vt[i].lat);
         check_int($sformatf("vec%0d.reg_write", i), o.rw, vt[i].rw);
         check_int($sformatf("vec%0d.retired", i), o.ret, vt[i].ret);
         check_int($sformatf("vec%0d.illegal", i), o.ill, vt[i].ill);
         if (vt[i].ret != 0) check_int($sformatf("vec%0d.alu_ctrl", i), o.alu, vt[i].alu);
         check_obs($sformatf("vec%0d", i), o, model(vt[i].ins, vt[i].fw, vt[i].mw));
      end

      // Fetch watchdog: never ready, expires after TMO wait cycles and parks in IDLE.
      run_instr(32'h012A4020, 10, 0, 1'b0, o);
      check_obs("wd_fetch", o, model(32'h012A4020, 10, 0));
      run = 1'b1; bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         if (state_dbg != 3'd0 || mem_req) bad++;
      end
      check_int("wd_park_idle", bad, 0);
      check_int("wd_sticky", int'(bus_error), 1);
      run = 1'b0;
      do_reset();

      // Ready on the expiring cycle completes normally.
      run_instr(32'h8D090004, 3, 3, 1'b0, o);
      check_obs("wd_edge", o, model(32'h8D090004, 3, 3));

      // Store watchdog in MEM: no retire, sticky error.
      run_instr(32'hAD090008, 0, 7, 1'b0, o);
      check_obs("wd_mem", o, model(32'hAD090008, 0, 7));
      do_reset();

      // run dropped mid-instruction: completes, then parks.
      run_instr(32'h8D090004, 1, 1, 1'b1, o);
      check_obs("run_drop", o, model(32'h8D090004, 1, 1));
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         if (state_dbg != 3'd0) bad++;
      end
      check_int("run_drop_park", bad, 0);

      // Reset asserted during MEM of an LW.
      instr = 32'h8D090004; run = 1'b1; n = 0;
      while (state_dbg != 3'd4 && n < 20) begin
         @(posedge clk); #1;
         mem_ready = (state_dbg == 3'd1);
         #1;
         n++;
      end
      check_int("rst_reach_mem", int'(state_dbg), 4);
      check_int("rst_mem_req_on", int'(mem_req), 1);
      #1; rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
      #1;
      check_int("rst_async_state",   int'(state_dbg), 0);
      check_int("rst_async_mem_req", int'(mem_req),   0);
      check_int("rst_async_reg_wr",  int'(reg_write), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check_int("rst_release_mem_req", int'(mem_req), 0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         if (reg_write || retired || mem_req || state_dbg != 3'd0) bad++;
      end
      check_int("rst_no_writeback", bad, 0);

      // Randomized instructions against the model.
      for (int i = 0; i < 40; i++) begin
         int fw; int mw;
         r   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: ins = {6'h00, r[25:6], 6'h20};
            1: ins = {6'h00, r[25:6], 6'h00};
            2: ins = {6'h00, r[25:6], 6'h24};
            3: ins = {6'h00, r[25:6], 6'h27};
            4: ins = {6'h08, r[25:0]};
            5: ins = {6'h0C, r[25:0]};
            6: ins = {6'h23, r[25:0]};
            7: ins = {6'h2B, r[25:0]};
            default: ins = r;
         endcase
         fw = $urandom_range(0, TMO - 1);
         mw = $urandom_range(0, TMO - 1);
         run_instr(ins, fw, mw, 1'b0, o);
         e = model(ins, fw, mw);
         check_obs($sformatf("rnd%0d_%08h", i, ins), o, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle control FSM for the single-ALU MIPS datapath. It owns the 4-bit ALU control code and all datapath enables, and sequences each instruction through fetch, decode, execute, memory and writeback. It handshakes with the unified instruction/data memory port and includes a memory-wait watchdog. It sits between the instruction register / memory interface and the ALU, register file and PC.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a mem_req may wait for mem_ready before bus_error (1..2^CNT_W-1)
CNT_W, 8, width of the watchdog counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enables instruction sequencing; sampled only in IDLE
instr  in  32  instruction register contents, stable from the cycle after ir_write
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request, held until mem_ready or timeout
mem_we  out  1  write strobe, valid with mem_req
ir_write  out  1  one-cycle pulse: capture fetched word into IR
pc_write  out  1  one-cycle pulse: PC <= PC+4
alu_ctrl  out  4  ALU operation code
alu_src_imm  out  1  ALU in2 = sign/zero-extended immediate (ANDI zero-extends)
reg_dst_rd  out  1  write-back register = rd (R-type), else rt
mem_to_reg  out  1  write-back data from memory (LW)
reg_write  out  1  one-cycle register-file write enable
retired  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse on an undecodable instruction
bus_error  out  1  sticky; set on watchdog expiry, cleared only by reset
state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low. On reset: state=IDLE, watchdog=0, latched decode cleared, all outputs 0 (alu_ctrl=4'b0000).
- Decode (combinational on instr; latched into registers on the DECODE cycle and held through WB):
  - op 0x00, funct 0x20 -> ADD 0000
  - op 0x08 -> ADDI 0001
  - op 0x23 -> LW 0010
  - op 0x2B -> SW 0011
  - op 0x00, funct 0x00 -> SLL 0100
  - op 0x00, funct 0x24 -> AND 0101
  - op 0x0C -> ANDI 0110
  - op 0x00, funct 0x27 -> NOR 0111
  - anything else -> illegal
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- IDLE: no outputs asserted. run=1 -> FETCH. Stays in IDLE while bus_error=1.
- FETCH: mem_req=1, mem_we=0.
  - mem_ready=1 -> ir_write=1, pc_write=1 in the same cycle, go to DECODE.
  - Otherwise wait.
- DECODE: latch the decode result.
  - Illegal -> illegal=1 for 1 cycle, no writes, go to IDLE.
  - Otherwise go to EXEC.
- EXEC: alu_ctrl, alu_src_imm and reg_dst_rd are valid.
  - LW/SW -> MEM.
  - All other legal ops -> WB.
  - alu_ctrl holds its latched value from EXEC through the end of MEM/WB, then returns to 0000 in IDLE/FETCH.
- MEM: mem_req=1, mem_we=1 only for SW.
  - mem_ready with SW -> retired=1, go to IDLE.
  - mem_ready with LW -> WB.
- WB: reg_write=1, mem_to_reg=1 for LW, retired=1, go to IDLE.
- IDLE to FETCH costs 1 cycle. With mem_ready=1 immediately, per-instruction latency is:
  - ALU ops: IDLE,FETCH,DECODE,EXEC,WB = 5 cycles
  - LW: 6 cycles
  - SW: 5 cycles
- Watchdog:
  - Counts each cycle in FETCH or MEM with mem_ready=0; clears on mem_ready or state exit.
  - At count==TIMEOUT_CYCLES: set bus_error, drop mem_req, go to IDLE. No ir_write, reg_write or retired for that instruction.
  - mem_ready arriving in the same cycle as expiry wins: the access completes and no error is raised.
- run deasserting mid-instruction has no effect; the instruction completes and the block then parks in IDLE.
- Reset mid-operation forces IDLE immediately. mem_req and reg_write drop asynchronously, with no partial write-back.
- mem_req must never be asserted in the cycle reset deasserts.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU_* codes (ADD..NOR)
  - OP_*/FUNCT_* opcode constants
  - the state encoding constants
- The datapath ALU and this controller both import alu_pkg.
- One sub-module, alu_seq_decode: a purely combinational instr -> {alu_ctrl, alu_src_imm, reg_dst_rd, is_mem, is_store, illegal}.

Test Plan:
- ADD: run=1, instr=0x012A4020, mem_ready always 1 -> ir_write@FETCH, alu_ctrl=0000 @EXEC, reg_write+reg_dst_rd+retired @WB, 5 cycles total.
- LW: instr=0x8D090004 with mem_ready delayed 3 cycles in MEM -> alu_ctrl=0010, alu_src_imm=1, mem_we=0, WB with mem_to_reg=1, 9 cycles.
- SW + ANDI: SW 0xAD090008 -> mem_we=1 in MEM, no reg_write, retired at MEM exit. ANDI 0x3128000F -> alu_ctrl=0110.
- Illegal: instr=0xFC000000 -> illegal pulse in DECODE, no reg_write/mem_req after FETCH, returns to IDLE.
- Watchdog: TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> bus_error after 4 wait cycles, mem_req drops, stays IDLE with run=1. Repeat with mem_ready on cycle 4 -> no error.
- Reset: assert rst_n=0 during MEM of LW -> mem_req=0 and state_dbg=0 before the next clock edge; no reg_write follows.
